// File: rtl/column_buffer.sv
// rtl/column_buffer.sv - double-buffered per-column wall store; swaps front/back at vertical blank.
// Optional swap-done interrupt enabled by defining COLUMN_BUFFER_IRQ_EN.
module column_buffer #(
    parameter int NCOLS = 640,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          chipselect,
    input  logic          write,
    input  logic          read,
    input  logic [1:0]    address,
    input  logic [15:0]   writedata,
    output logic [15:0]   readdata,
    input  logic          frame_end,
    input  logic [CW-1:0] col,
    input  logic          col_rd,
    output logic [8:0]    col_height,
    output logic [6:0]    col_shade,
    output logic          col_valid,
    output logic          irq
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_swap;
    logic          r_front;
    logic [CW-1:0] r_wptr;
    logic          r_overrun;
    logic          w_irq_bit;

    logic [15:0]   r_ram0 [NCOLS];
    logic [15:0]   r_ram1 [NCOLS];
    logic [15:0]   r_q0;
    logic [15:0]   r_q1;
    logic          r_sel;
    logic          r_oob;
    logic          r_have;
    logic          r_col_valid;
    logic [15:0]   w_col_word;

    logic          w_wr;
    logic          w_addr_wr;
    logic          w_data_wr;
    logic          w_ctrl_wr;
    logic          w_addr_ok;
    logic          w_data_ok;
    logic          w_col_ok;
    logic [CW-1:0] w_wptr_inc;

    assign w_wr       = chipselect && write;
    assign w_addr_wr  = w_wr && (address == 2'd0);
    assign w_data_wr  = w_wr && (address == 2'd1);
    assign w_ctrl_wr  = w_wr && (address == 2'd2);
    assign w_addr_ok  = 32'(writedata[CW-1:0]) < NCOLS;
    assign w_data_ok  = w_data_wr && (r_state == IDLE);
    assign w_col_ok   = 32'(col) < NCOLS;
    assign w_wptr_inc = (r_wptr == CW'(NCOLS - 1)) ? '0 : r_wptr + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ctrl_wr && writedata[0])
                    w_state_next = PENDING;
            end
            PENDING: begin
                if (frame_end) begin
                    w_state_next = IDLE;
                    w_swap       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_front   <= 1'b0;
            r_wptr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_swap) begin
                r_front <= ~r_front;
                r_wptr  <= '0;
            end else if (w_data_ok) begin
                r_wptr <= w_wptr_inc;
            end else if (w_addr_wr && w_addr_ok) begin
                r_wptr <= writedata[CW-1:0];
            end
            // A dropped write wins over a clear issued in the same cycle.
            if (w_data_wr && (r_state == PENDING))
                r_overrun <= 1'b1;
            else if (w_ctrl_wr && writedata[1])
                r_overrun <= 1'b0;
        end
    end

`ifdef COLUMN_BUFFER_IRQ_EN
    logic r_irq_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_irq_flag <= 1'b0;
        else if (w_swap)
            r_irq_flag <= 1'b1;
        else if (w_ctrl_wr && writedata[2])
            r_irq_flag <= 1'b0;
    end

    assign irq       = r_irq_flag;
    assign w_irq_bit = r_irq_flag;
`else
    assign irq       = 1'b0;
    assign w_irq_bit = 1'b0;
`endif

    // RAM arrays carry no reset so they can map onto block memory.
    always_ff @(posedge clk) begin
        if (w_data_ok) begin
            if (r_front)
                r_ram0[r_wptr] <= writedata;
            else
                r_ram1[r_wptr] <= writedata;
        end
        if (col_rd && w_col_ok) begin
            r_q0 <= r_ram0[col];
            r_q1 <= r_ram1[col];
        end
    end

    // r_sel captures front before a same-edge swap, so such a fetch sees old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col_valid <= 1'b0;
            r_have      <= 1'b0;
            r_sel       <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            r_col_valid <= col_rd;
            if (col_rd) begin
                r_have <= 1'b1;
                r_sel  <= r_front;
                r_oob  <= ~w_col_ok;
            end
        end
    end

    assign w_col_word = (!r_have || r_oob) ? 16'h0000 : (r_sel ? r_q1 : r_q0);
    assign col_height = w_col_word[8:0];
    assign col_shade  = w_col_word[15:9];
    assign col_valid  = r_col_valid;

    always_comb begin
        readdata = '0;
        if (chipselect && read) begin
            case (address)
                2'd0:    readdata = 16'(r_wptr);
                2'd3:    readdata = {12'b0, w_irq_bit, r_overrun, r_front, r_state == PENDING};
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_column_buffer.sv
// tb/tb_column_buffer.sv - directed table-driven bench for column_buffer.
module tb_column_buffer;

    localparam int NCOLS = 640;
    localparam int CW    = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          chipselect;
    logic          write;
    logic          read;
    logic [1:0]    address;
    logic [15:0]   writedata;
    logic [15:0]   readdata;
    logic          frame_end;
    logic [CW-1:0] col;
    logic          col_rd;
    logic [8:0]    col_height;
    logic [6:0]    col_shade;
    logic          col_valid;
    logic          irq;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    column_buffer #(.NCOLS(NCOLS), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata), .readdata(readdata),
        .frame_end(frame_end), .col(col), .col_rd(col_rd), .col_height(col_height),
        .col_shade(col_shade), .col_valid(col_valid), .irq(irq)
    );

    typedef struct {
        int          op;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;

    localparam int OP_WR = 0, OP_RD = 1, OP_FETCH = 2, OP_FE = 3;

    vec_t tv[$];

    function automatic void add(int op, logic [1:0] a, logic [15:0] d, logic [15:0] e, string n);
        tv.push_back('{op, a, d, e, n});
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic av_wr(input logic [1:0] a, input logic [15:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic av_rd(input logic [1:0] a, input logic [15:0] exp, input string name);
        chipselect = 1'b1; read = 1'b1; address = a;
        #1;
        chk(name, readdata, exp);
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic fetch(input int c, input logic [15:0] exp_word, input string name);
        col = CW'(c); col_rd = 1'b1;
        @(negedge clk);
        col_rd = 1'b0;
        chk({name, " valid"}, 16'(col_valid), 16'h0001);
        chk({name, " data"}, {col_shade, col_height}, exp_word);
    endtask

    task automatic pulse_fe();
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; frame_end = 1'b0; col = '0; col_rd = 1'b0;

        // Wrap, address range, overrun and swap-back sequence.
        add(OP_WR,    2'd0, 16'd639,   16'h0000, "");
        add(OP_WR,    2'd1, 16'hAAAA,  16'h0000, "");
        add(OP_WR,    2'd1, 16'h5555,  16'h0000, "");
        add(OP_RD,    2'd0, 16'h0000,  16'h0001, "wrap wptr");
        add(OP_WR,    2'd0, 16'd800,   16'h0000, "");
        add(OP_RD,    2'd0, 16'h0000,  16'h0001, "oob col_addr ignored");
        add(OP_WR,    2'd2, 16'h0001,  16'h0000, "");
        add(OP_RD,    2'd3, 16'h0000,  16'h0003, "status pending");
        add(OP_WR,    2'd1, 16'h1234,  16'h0000, "");
        add(OP_RD,    2'd3, 16'h0000,  16'h0007, "overrun set");
        add(OP_RD,    2'd0, 16'h0000,  16'h0001, "wptr frozen on overrun");
        add(OP_WR,    2'd2, 16'h0002,  16'h0000, "");
        add(OP_RD,    2'd3, 16'h0000,  16'h0003, "overrun cleared");
        add(OP_WR,    2'd2, 16'h0001,  16'h0000, "");
        add(OP_RD,    2'd3, 16'h0000,  16'h0003, "request while pending");
        add(OP_FE,    2'd0, 16'h0000,  16'h0000, "");
        add(OP_WR,    2'd2, 16'h0004,  16'h0000, "");
        add(OP_RD,    2'd3, 16'h0000,  16'h0000, "status after swap back");
        add(OP_RD,    2'd0, 16'h0000,  16'h0000, "wptr zeroed by swap");
        add(OP_FETCH, 2'd0, 16'd639,   16'hAAAA, "wrap col 639");
        add(OP_FETCH, 2'd0, 16'd0,     16'h5555, "wrap col 0");
        add(OP_FETCH, 2'd0, 16'd1023,  16'h0000, "oob col 1023");

        repeat (3) @(negedge clk);
        chk("reset col_valid", 16'(col_valid), 16'h0000);
        chk("reset col data", {col_shade, col_height}, 16'h0000);
        chk("reset irq", 16'(irq), 16'h0000);
        av_rd(2'd3, 16'h0000, "reset status in reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        col = CW'(5); col_rd = 1'b1;
        @(negedge clk);
        col_rd = 1'b0;
        chk("first fetch valid", 16'(col_valid), 16'h0001);
        @(negedge clk);
        chk("valid drops", 16'(col_valid), 16'h0000);
        av_rd(2'd3, 16'h0000, "status after reset");
        av_rd(2'd0, 16'h0000, "wptr after reset");

        av_wr(2'd0, 16'h0000);
        for (int i = 0; i < NCOLS; i++) av_wr(2'd1, 16'(i));
        av_rd(2'd0, 16'h0000, "wptr wrapped after fill");
        av_wr(2'd2, 16'h0001);
        av_rd(2'd3, 16'h0001, "fill pending");
        fetch(639, 16'h0000, "pre-swap col 639 old front empty");
        pulse_fe();
`ifdef COLUMN_BUFFER_IRQ_EN
        chk("irq after swap", 16'(irq), 16'h0001);
        av_rd(2'd3, 16'h000A, "status with irq flag");
`endif
        av_wr(2'd2, 16'h0004);
`ifdef COLUMN_BUFFER_IRQ_EN
        chk("irq cleared", 16'(irq), 16'h0000);
`endif
        av_rd(2'd3, 16'h0002, "status after fill swap");
        fetch(639, 16'h027F, "fill col 639");
        fetch(0,   16'h0000, "fill col 0");
        fetch(700, 16'h0000, "oob col 700");
        fetch(300, 16'd300,  "fill col 300");
        @(negedge clk);
        chk("valid low when idle", 16'(col_valid), 16'h0000);
        chk("data held", {col_shade, col_height}, 16'd300);

        for (int k = 0; k < 4; k++) begin
            col = CW'(10 + k); col_rd = 1'b1;
            @(negedge clk);
            chk("b2b valid", 16'(col_valid), 16'h0001);
            chk("b2b data", {col_shade, col_height}, 16'(10 + k));
        end
        col_rd = 1'b0;

        foreach (tv[i]) begin
            case (tv[i].op)
                OP_WR:    av_wr(tv[i].addr, tv[i].data);
                OP_RD:    av_rd(tv[i].addr, tv[i].exp, tv[i].name);
                OP_FETCH: fetch(int'(tv[i].data), tv[i].exp, tv[i].name);
                default:  pulse_fe();
            endcase
        end
        @(negedge clk);

        // Request in the same cycle as frame_end only arms the swap.
        chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 16'h0001; frame_end = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; frame_end = 1'b0;
        av_rd(2'd3, 16'h0001, "same-cycle req no swap");
        @(negedge clk);
        frame_end = 1'b1; col = CW'(639); col_rd = 1'b1;
        @(negedge clk);
        frame_end = 1'b0; col_rd = 1'b0;
        chk("swap-cycle fetch old data", {col_shade, col_height}, 16'hAAAA);
        av_wr(2'd2, 16'h0004);
        av_rd(2'd3, 16'h0002, "status after delayed swap");
        fetch(639, 16'h027F, "new front col 639");

        av_wr(2'd0, 16'd5);
        av_wr(2'd1, 16'h0123);
        fetch(5, 16'd5, "back write hidden");
        av_wr(2'd2, 16'h0001);
        pulse_fe();
        av_wr(2'd2, 16'h0004);
        fetch(5, 16'h0123, "back write visible after swap");

        av_wr(2'd2, 16'h0001);
        pulse_fe();
        av_wr(2'd2, 16'h0001);
        col = CW'(3); col_rd = 1'b1;
        @(posedge clk);
        #5;
        reset_n = 1'b0;
        col_rd = 1'b0;
        av_rd(2'd3, 16'h0000, "reset mid-pending status");
        chk("reset mid-fetch valid", 16'(col_valid), 16'h0000);
        chk("reset mid-fetch data", {col_shade, col_height}, 16'h0000);
`ifdef COLUMN_BUFFER_IRQ_EN
        chk("reset clears irq", 16'(irq), 16'h0000);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        av_rd(2'd0, 16'h0000, "wptr after mid reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
